// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter sequencing controller.
package counter_ctrl_pkg;

  localparam int CTRL_WIDTH      = 8;
  localparam int CTRL_PRESCALE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_tick_prescaler.sv
// Programmable divider: tick is high when the running count equals the captured limit.
module tick_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] limit,
  input  logic                  enable,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] pre_lim;

  assign tick = (pre_cnt == pre_lim);

  // The limit is latched on load only, so mid-run changes to the source are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pre_lim <= '0;
    end else if (load) begin
      pre_cnt <= '0;
      pre_lim <= limit;
    end else if (enable) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run-to-terminal sequencer for an external counter: clear, prescaled count, done pulse.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int               WIDTH      = CTRL_WIDTH,
  parameter int               PRESCALE_W = CTRL_PRESCALE_W,
  parameter logic [WIDTH-1:0] TERMINAL   = WIDTH'(8'hFF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      q,
  output logic                  clear,
  output logic                  count,
  output logic                  busy,
  output logic                  done
);

  state_t state, state_nxt;
  logic   pre_load, pre_en, tick;

  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clock  (clock),
    .reset  (reset),
    .load   (pre_load),
    .limit  (prescale),
    .enable (pre_en),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs decode from state, so async reset forces them low immediately.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    count     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pre_load  = 1'b0;
    pre_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        clear     = 1'b1;
        busy      = 1'b1;
        pre_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        pre_en = 1'b1;
        // Never enable at terminal so the counter cannot wrap.
        count  = tick && (q != TERMINAL);
        if (q == TERMINAL) state_nxt = DONE;
        else if (stop)     state_nxt = IDLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench: three controllers (TERMINAL 5, 0, FF) each driving a behavioural counter.
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stop = 1'b0;
  logic [15:0] prescale = '0;
  logic        start_a = 1'b0, start_z = 1'b0, start_f = 1'b0;
  logic        clear_a, count_a, busy_a, done_a;
  logic        clear_z, count_z, busy_z, done_z;
  logic        clear_f, count_f, busy_f, done_f;
  logic [7:0]  q_a = '0, q_z = '0, q_f = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8), .PRESCALE_W(16), .TERMINAL(8'd5)) dut_a (
    .clock(clk), .reset(rst), .start(start_a), .stop(stop), .prescale(prescale),
    .q(q_a), .clear(clear_a), .count(count_a), .busy(busy_a), .done(done_a));
  counter_ctrl #(.WIDTH(8), .PRESCALE_W(16), .TERMINAL(8'd0)) dut_z (
    .clock(clk), .reset(rst), .start(start_z), .stop(stop), .prescale(prescale),
    .q(q_z), .clear(clear_z), .count(count_z), .busy(busy_z), .done(done_z));
  counter_ctrl #(.WIDTH(8), .PRESCALE_W(16), .TERMINAL(8'hFF)) dut_f (
    .clock(clk), .reset(rst), .start(start_f), .stop(stop), .prescale(prescale),
    .q(q_f), .clear(clear_f), .count(count_f), .busy(busy_f), .done(done_f));

  // Counter models: synchronous clear, increment enable, not touched by reset.
  always @(posedge clk) begin
    if (clear_a) q_a <= '0; else if (count_a) q_a <= q_a + 8'd1;
    if (clear_z) q_z <= '0; else if (count_z) q_z <= q_z + 8'd1;
    if (clear_f) q_f <= '0; else if (count_f) q_f <= q_f + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run on dut_a with P=2, T=5 from CLEAR through DONE; optional disturbances.
  task automatic run_p2(input bit disturb);
    for (int r = 0; r <= 16; r++) begin
      step();
      if (disturb && r == 5) start_a = 1'b0;
      chk($sformatf("count r=%0d", r), count_a, (r % 3 == 2) && (r < 15));
      chk($sformatf("busy r=%0d", r), busy_a, r <= 15);
      chk($sformatf("done r=%0d", r), done_a, r == 16);
      chk($sformatf("clear r=%0d", r), clear_a, 1'b0);
      if (r == 15) chk("q at terminal", q_a, 8'd5);
      if (disturb && r == 1)  prescale = 16'd0;
      if (disturb && r == 4)  start_a = 1'b1;
      if (disturb && r == 16) start_a = 1'b1;
    end
    step();
    start_a = 1'b0;
    chk("post done outputs", {clear_a, count_a, busy_a, done_a}, 4'b0000);
  endtask

  initial begin
    int n, pulses;
    #2;
    chk("reset outputs", {clear_a, count_a, busy_a, done_a}, 4'b0000);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle outputs", {clear_a, count_a, busy_a, done_a}, 4'b0000);

    // Stop alone in IDLE is ignored.
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle stop ignored", {clear_a, busy_a}, 2'b00);

    // Nominal run.
    prescale = 16'd2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("clear cycle", {clear_a, busy_a, count_a, done_a}, 4'b1100);
    run_p2(1'b0);
    step();
    chk("idle after done", {clear_a, busy_a}, 2'b00);

    // Abort at r=7 with start and stop together.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int r = 0; r <= 7; r++) step();
    chk("q before abort", q_a, 8'd2);
    stop = 1'b1;
    start_a = 1'b1;
    step();
    stop = 1'b0;
    start_a = 1'b0;
    chk("abort outputs", {clear_a, count_a, busy_a, done_a}, 4'b0000);
    step(); step();
    chk("q held after abort", q_a, 8'd2);
    chk("no done after abort", done_a, 1'b0);

    // Start+stop in IDLE begins a run; prescale change and start mid-run ignored.
    start_a = 1'b1;
    stop = 1'b1;
    step();
    start_a = 1'b0;
    stop = 1'b0;
    chk("collide clear", clear_a, 1'b1);
    run_p2(1'b1);
    chk("q after disturbed run", q_a, 8'd5);
    step();
    chk("start in done ignored", {clear_a, busy_a}, 2'b00);

    // Asynchronous reset mid-run at r=4.
    prescale = 16'd2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("reset run clear", clear_a, 1'b1);
    for (int r = 0; r <= 4; r++) step();
    chk("busy before reset", busy_a, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("async reset outputs", {clear_a, count_a, busy_a, done_a}, 4'b0000);
    #1 rst = 1'b0;
    step();
    chk("idle after reset", {clear_a, count_a, busy_a, done_a}, 4'b0000);
    chk("q holds over reset", q_a, 8'd1);

    // TERMINAL = 0: zero count pulses, done three edges after start.
    start_z = 1'b1;
    step();
    start_z = 1'b0;
    chk("t0 clear", {clear_z, count_z}, 2'b10);
    step();
    chk("t0 run", {count_z, busy_z, done_z}, 3'b010);
    step();
    chk("t0 done", {count_z, busy_z, done_z}, 3'b001);
    step();
    chk("t0 idle", done_z, 1'b0);
    chk("t0 q", q_z, 8'd0);

    // TERMINAL = FF, prescale 0: 255 consecutive pulses, done at edge 258.
    prescale = 16'd0;
    start_f = 1'b1;
    step();
    start_f = 1'b0;
    n = 1;
    pulses = 0;
    while (!done_f && n < 400) begin
      if (count_f) pulses++;
      step();
      n++;
    end
    chk("ff done latency", n, 258);
    chk("ff pulses", pulses, 255);
    chk("ff q", q_f, 8'hFF);
    step();
    chk("ff idle", {busy_f, done_f, count_f}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
